// File: rtl/rsa_if_pkg.sv
// Shared command codes, FSM state encoding and default widths for the RSA host interface.
package rsa_if_pkg;

  localparam int DATA_W_DEF = 1024;
  localparam int CMD_W_DEF  = 32;

  typedef enum logic [2:0] {
    CMD_COMPUTE_EXP  = 3'd0,
    CMD_COMPUTE_MONT = 3'd1,
    CMD_RD_MOD       = 3'd2,
    CMD_RD_RSQ       = 3'd3,
    CMD_RD_EXP       = 3'd4,
    CMD_WRITE        = 3'd5
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RX    = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    TX    = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/rsa_host_if.sv
// Host-side command/data responder: loads operands, launches the core, returns the result.
// state | meaning
// IDLE  | waiting for a command
// RX    | receiving one operand word
// ISSUE | one-cycle core launch
// WAIT  | waiting for core_done
// TX    | presenting the result word
// DONE  | done held until host acknowledges
module rsa_host_if
  import rsa_if_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CMD_W  = CMD_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CMD_W-1:0]  arm_to_fpga_cmd,
  input  logic              arm_to_fpga_cmd_valid,
  output logic              fpga_to_arm_done,
  input  logic              fpga_to_arm_done_read,
  input  logic [DATA_W-1:0] arm_to_fpga_data,
  input  logic              arm_to_fpga_data_valid,
  output logic              arm_to_fpga_data_ready,
  output logic [DATA_W-1:0] fpga_to_arm_data,
  output logic              fpga_to_arm_data_valid,
  input  logic              fpga_to_arm_data_ready,
  output logic [DATA_W-1:0] mod_q,
  output logic [DATA_W-1:0] rsq_q,
  output logic [DATA_W-1:0] exp_q,
  output logic              core_start,
  output logic              core_op,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [3:0]        leds
);

  state_e            state_q, state_d;
  logic [2:0]        cmd_q, cmd_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mod_d, rsq_d, exp_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              cmd_hi_unused;

  assign cmd_hi_unused = ^arm_to_fpga_cmd[CMD_W-1:3];

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    mod_d   = mod_q;
    rsq_d   = rsq_q;
    exp_d   = exp_q;
    res_d   = res_q;

    // A command strobe anywhere but IDLE is dropped and flagged.
    if (arm_to_fpga_cmd_valid && state_q != IDLE) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (arm_to_fpga_cmd_valid) begin
          cmd_d = arm_to_fpga_cmd[2:0];
          case (arm_to_fpga_cmd[2:0])
            CMD_COMPUTE_EXP, CMD_COMPUTE_MONT: state_d = ISSUE;
            CMD_RD_MOD, CMD_RD_RSQ, CMD_RD_EXP: state_d = RX;
            CMD_WRITE: state_d = TX;
            default: begin
              state_d = DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      RX: begin
        if (arm_to_fpga_data_valid) begin
          case (cmd_q)
            CMD_RD_MOD: mod_d = arm_to_fpga_data;
            CMD_RD_RSQ: rsq_d = arm_to_fpga_data;
            default:    exp_d = arm_to_fpga_data;
          endcase
          state_d = DONE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (core_done) begin
          res_d   = core_result;
          state_d = DONE;
        end
      end
      TX: begin
        if (fpga_to_arm_data_ready) state_d = DONE;
      end
      DONE: begin
        if (fpga_to_arm_done_read) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cmd_q   <= 3'd0;
      err_q   <= 1'b0;
      mod_q   <= '0;
      rsq_q   <= '0;
      exp_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      mod_q   <= mod_d;
      rsq_q   <= rsq_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
    end
  end

  // All handshake outputs decode straight from the registered state.
  assign arm_to_fpga_data_ready = (state_q == RX);
  assign fpga_to_arm_data_valid = (state_q == TX);
  assign fpga_to_arm_done       = (state_q == DONE);
  assign fpga_to_arm_data       = res_q;
  assign core_start             = (state_q == ISSUE);
  assign core_op                = ((state_q == ISSUE) || (state_q == WAIT)) &&
                                  (cmd_q == CMD_COMPUTE_MONT);
  assign leds                   = {err_q, state_q};

endmodule

// File: tb/tb_rsa_host_if.sv
// Directed self-checking bench for rsa_host_if: operand loads, compute, readback, abuse, reset.
module tb_rsa_host_if;

  localparam int DW = 1024;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [CW-1:0] cmd;
  logic          cmd_valid;
  logic          done;
  logic          done_read;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] mod_q, rsq_q, exp_q;
  logic          core_start, core_op, core_done;
  logic [DW-1:0] core_result;
  logic [3:0]    leds;

  int total = 0;
  int bad   = 0;

  rsa_host_if #(.DATA_W(DW), .CMD_W(CW)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .arm_to_fpga_cmd        (cmd),
    .arm_to_fpga_cmd_valid  (cmd_valid),
    .fpga_to_arm_done       (done),
    .fpga_to_arm_done_read  (done_read),
    .arm_to_fpga_data       (din),
    .arm_to_fpga_data_valid (din_valid),
    .arm_to_fpga_data_ready (din_ready),
    .fpga_to_arm_data       (dout),
    .fpga_to_arm_data_valid (dout_valid),
    .fpga_to_arm_data_ready (dout_ready),
    .mod_q                  (mod_q),
    .rsq_q                  (rsq_q),
    .exp_q                  (exp_q),
    .core_start             (core_start),
    .core_op                (core_op),
    .core_done              (core_done),
    .core_result            (core_result),
    .leds                   (leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    c;
    logic [DW-1:0] data;
    logic [DW-1:0] e_mod;
    logic [DW-1:0] e_rsq;
    logic [DW-1:0] e_exp;
    logic          e_err;
  } vec_t;

  vec_t vecs[5];

  logic [DW-1:0] d0, d1, d2, d3, d4, d5, junk;
  logic [DW-1:0] r_exp, r_mont;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c);
    cmd       = {29'h1abcd000, c};
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic ack_done();
    chk("done_high_before_ack", done, 1);
    tick();
    chk("done_held_without_ack", done, 1);
    done_read = 1'b1;
    tick();
    done_read = 1'b0;
    chk("done_low_after_ack", done, 0);
    chk("state_idle_after_ack", leds[2:0], 0);
  endtask

  // Data valid is raised before the command so it is already high when ready rises.
  task automatic write_word(input logic [2:0] c, input logic [DW-1:0] w);
    int rdy_cnt = 0;
    bit got = 0;
    din       = w;
    din_valid = 1'b1;
    send_cmd(c);
    for (int n = 0; n < 20 && !got; n++) begin
      if (din_ready) rdy_cnt++;
      tick();
      if (done) got = 1;
    end
    din_valid = 1'b0;
    chk("rx_done_seen", done, 1);
    chk("rx_ready_cycles", rdy_cnt, 1);
    chk("rx_ready_dropped", din_ready, 0);
  endtask

  task automatic compute(input logic [2:0] c, input logic [DW-1:0] res, input logic op,
                         input bit abuse);
    send_cmd(c);
    chk("core_start_issue", core_start, 1);
    chk("core_op_issue", core_op, op);
    tick();
    chk("core_start_single", core_start, 0);
    chk("core_op_wait", core_op, op);
    if (abuse) begin
      cmd       = 32'd1;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("err_after_cmd_in_wait", leds[3], 1);
      chk("still_wait", leds[2:0], 3);
    end else begin
      tick();
    end
    chk("core_start_stays_low", core_start, 0);
    tick();
    core_done   = 1'b1;
    core_result = res;
    chk("done_before_core_done", done, 0);
    tick();
    core_done   = 1'b0;
    core_result = '0;
    chk("done_after_core_done", done, 1);
    chk("core_op_cleared", core_op, 0);
  endtask

  task automatic read_result(input logic [DW-1:0] exp);
    send_cmd(3'd5);
    chk("tx_valid", dout_valid, 1);
    chk("tx_data", dout, exp);
    tick();
    tick();
    chk("tx_valid_held", dout_valid, 1);
    chk("tx_data_stable", dout, exp);
    chk("tx_no_done_yet", done, 0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("tx_valid_dropped", dout_valid, 0);
    chk("tx_done", done, 1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    resetn      = 1'b0;
    cmd         = '0;
    cmd_valid   = 1'b0;
    done_read   = 1'b0;
    din         = '0;
    din_valid   = 1'b0;
    dout_ready  = 1'b0;
    core_done   = 1'b0;
    core_result = '0;

    d0     = {16'hd97a, 992'h0, 16'h5885};
    d1     = {32{32'h1111_2222}};
    d2     = {32{32'h0bad_f00d}};
    d3     = {{16{32'haaaa_0001}}, {16{32'hbbbb_0002}}};
    d4     = {32{32'h89ab_cdef}};
    d5     = {32{32'h7777_3333}};
    junk   = {32{32'hdead_beef}};
    r_exp  = 1024'h5eed_c0de;
    r_mont = 1024'h1234;

    vecs[0] = '{3'd2, d0, d0, '0, '0, 1'b0};
    vecs[1] = '{3'd4, d2, d0, '0, d2, 1'b0};
    vecs[2] = '{3'd3, d1, d0, d1, d2, 1'b0};
    vecs[3] = '{3'd3, d3, '0, d3, '0, 1'b0};
    vecs[4] = '{3'd2, d4, d4, d3, '0, 1'b0};

    do_reset();
    chk("rst_done", done, 0);
    chk("rst_ready", din_ready, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_leds", leds, 0);
    chk("rst_mod", mod_q, 0);
    chk("rst_dout", dout, 0);

    for (int i = 0; i < 3; i++) begin
      write_word(vecs[i].c, vecs[i].data);
      chk("tbl_mod", mod_q, vecs[i].e_mod);
      chk("tbl_rsq", rsq_q, vecs[i].e_rsq);
      chk("tbl_exp", exp_q, vecs[i].e_exp);
      chk("tbl_err", leds[3], vecs[i].e_err);
      ack_done();
    end

    compute(3'd0, r_exp, 1'b0, 1'b0);
    chk("exp_rsq_kept", rsq_q, d1);
    chk("exp_exp_kept", exp_q, d2);
    ack_done();
    read_result(r_exp);
    ack_done();

    send_cmd(3'd7);
    chk("illegal_done", done, 1);
    chk("illegal_no_rx", din_ready, 0);
    chk("illegal_no_tx", dout_valid, 0);
    chk("illegal_err", leds[3], 1);
    chk("illegal_state", leds[2:0], 5);
    ack_done();
    write_word(3'd4, d5);
    chk("err_sticky_exp", exp_q, d5);
    chk("err_sticky", leds[3], 1);
    ack_done();

    do_reset();
    chk("rst2_leds", leds, 0);
    chk("rst2_mod", mod_q, 0);
    chk("rst2_exp", exp_q, 0);

    for (int i = 3; i < 5; i++) begin
      write_word(vecs[i].c, vecs[i].data);
      chk("tbl_mod", mod_q, vecs[i].e_mod);
      chk("tbl_rsq", rsq_q, vecs[i].e_rsq);
      chk("tbl_exp", exp_q, vecs[i].e_exp);
      chk("tbl_err", leds[3], vecs[i].e_err);
      ack_done();
    end

    compute(3'd1, r_mont, 1'b1, 1'b1);
    chk("abuse_mod_kept", mod_q, d4);
    chk("abuse_rsq_kept", rsq_q, d3);
    ack_done();

    din       = junk;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    chk("idle_data_mod", mod_q, d4);
    chk("idle_data_rsq", rsq_q, d3);
    chk("idle_data_exp", exp_q, 0);
    chk("idle_data_state", leds[2:0], 0);

    read_result(r_mont);
    chk("err_still_set", leds[3], 1);
    ack_done();

    send_cmd(3'd5);
    chk("pre_rst_valid", dout_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", dout_valid, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_leds", leds, 0);
    chk("async_rst_start", core_start, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
    read_result('0);
    ack_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want test completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rsa_host_if.md
Name: rsa_host_if

Overview:
FPGA-side responder for the ARM command/data protocol, instantiated inside the RSA wrapper between the host bus and the exponentiation/Montgomery core.
- Decodes 32-bit commands and accepts 1024-bit operands into the modulus, RSQ and EXP registers.
- Launches the core and captures its result.
- Returns the result on the outbound data channel.
- Signals completion of every command with a level `done` that the host acknowledges.

Parameters:
- DATA_W, 1024: operand, result and data-bus width.
- CMD_W, 32: command word width.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- arm_to_fpga_cmd  in  CMD_W  command word.
- arm_to_fpga_cmd_valid  in  1  one-cycle command strobe.
- fpga_to_arm_done  out  1  command complete; held high until acknowledged.
- fpga_to_arm_done_read  in  1  host acknowledge of done.
- arm_to_fpga_data  in  DATA_W  inbound operand.
- arm_to_fpga_data_valid  in  1  inbound data valid.
- arm_to_fpga_data_ready  out  1  block ready to accept inbound data.
- fpga_to_arm_data  out  DATA_W  outbound result.
- fpga_to_arm_data_valid  out  1  outbound data valid.
- fpga_to_arm_data_ready  in  1  host ready for outbound data.
- mod_q  out  DATA_W  modulus register.
- rsq_q  out  DATA_W  RSQ register; holds R²mod m for EXP, or [A|B] for MONT.
- exp_q  out  DATA_W  EXP register; holds [Rmod|e].
- core_start  out  1  one-cycle core launch pulse.
- core_op  out  1  0 = exponentiation, 1 = Montgomery multiply.
- core_done  in  1  core finished (pulse or level; sampled only in WAIT).
- core_result  in  DATA_W  core result, valid when core_done is high.
- leds  out  4  status: [2:0] = state encoding, [3] = sticky error.

Behaviour:
Reset (resetn low, asynchronous):
- State = IDLE.
- All outputs = 0; mod_q, rsq_q, exp_q and the result register = 0; error flag = 0.

Commands (bits [2:0]; upper bits ignored):
- 0 EXP, 1 MONT, 2 RD_MOD, 3 RD_RSQ, 4 RD_EXP, 5 WRITE.
- Codes 6 and 7 are illegal.

State transitions:
- IDLE: on cmd_valid, register the command.
  - RD_* → RX.
  - EXP/MONT → ISSUE.
  - WRITE → TX.
  - Illegal code → DONE, and set the error flag.
- RX: data_ready = 1 (registered, so it is high the cycle after the command is accepted).
  - On valid & ready: load the 1024-bit word into the register selected by the command, drop ready, → DONE.
  - valid asserted before ready is legal; the word is captured at the first cycle both are high.
- ISSUE: core_start = 1 for exactly one cycle; core_op = (cmd == MONT), held stable until DONE → WAIT.
- WAIT: stay until core_done = 1; latch core_result into the result register → DONE.
- TX: data_valid = 1; fpga_to_arm_data = result register, stable while valid is high.
  - On valid & ready: drop valid → DONE.
  - WRITE before any compute returns the last result, or 0 after reset.
- DONE: fpga_to_arm_done = 1.
  - On done_read: done drops on the next edge → IDLE.
  - A new command is accepted at the earliest one cycle after done falls.

Boundary conditions:
- cmd_valid outside IDLE (including in DONE): command dropped, error flag set. The flag is sticky and cleared only by reset.
- done_read outside DONE: ignored.
- data_valid outside RX: ignored; the registers are unchanged.
- core_done outside WAIT: ignored.
- Reset mid-operation: immediate return to IDLE; a partial transfer is discarded; core_start is low.

Latency:
- Read command: done is high 1 cycle after the data handshake.
- Compute: done is high 1 cycle after core_done.

Decomposition:
- Package rsa_if_pkg:
  - command codes CMD_COMPUTE_EXP..CMD_WRITE (0..5);
  - state enum IDLE=0, RX=1, ISSUE=2, WAIT=3, TX=4, DONE=5;
  - DATA_W and CMD_W defaults.
- No sub-module. The operand register bank stays inline as three enable-loaded registers.

Test Plan:
- Read path: cmd 2, data 0x…d97a…5885 with valid held until ready → mod_q equals the data; done pulses high until done_read; data_ready is high for exactly one handshake cycle.
- MONT: cmd 3 with A|B, cmd 2 with m, cmd 1; stub core returns 0x1234 three cycles after core_start → core_start is a single cycle with core_op = 1; done follows core_done by 1 cycle; a subsequent cmd 5 returns fpga_to_arm_data = 0x1234 with valid held until ready.
- EXP: cmd 2, 4, 3, then 0 → core_op = 0; exp_q and rsq_q hold the sent words; result is read back via cmd 5.
- Illegal command 7 → done is asserted with no RX/TX activity; leds[3] = 1 and stays 1 after subsequent legal commands.
- Protocol abuse: cmd 1 pulsed while in WAIT, and data_valid pulsed in IDLE → the command is dropped and leds[3] = 1; registers are unchanged; the original operation completes normally.
- Reset during TX, with valid high and ready low → valid and done drop asynchronously; state = IDLE; the next cmd 5 returns 0.
